// File: rtl/s1_serializer_pkg.sv
// Shared frame constants and the serializer state encoding.
// The S2 receiver side uses the same frame geometry.
package s1_serializer_pkg;

  localparam int ADDR_BITS = 3;
  localparam int DATA_BITS = 18;
  localparam int FRAME_LEN = ADDR_BITS + DATA_BITS;
  localparam int NFRAMES   = 8;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/s1_serializer_if.sv
// RB1 read port plus the sen/sd serial link and completion flag.
// master = serializer side, slave = RB1 memory / receiver side.
interface s1_serializer_if;

  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;
  logic       sen;
  logic       sd;
  logic       S1_done;

  modport master (
    output RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
    input  RB1_Q
  );

  modport slave (
    input  RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
    output RB1_Q
  );

endinterface

// File: rtl/s1_bitplane_mux.sv
// Bit-plane select: word bit j is bit <plane> of byte j.
module s1_bitplane_mux
  import s1_serializer_pkg::*;
#(
  parameter int N = DATA_BITS
) (
  input  logic [7:0]           bytes_i [N],
  input  logic [ADDR_BITS-1:0] plane_i,
  output logic [N-1:0]         word_o
);

  // gather one bit from every buffered byte
  always_comb begin
    word_o = '0;
    for (int j = 0; j < N; j++) begin
      word_o[j] = bytes_i[j][plane_i];
    end
  end

endmodule

// File: rtl/s1_serializer.sv
// S1 serializer: reads RB1 once, transposes into bit planes and ships
// eight {addr, data} frames over sen/sd, MSB first.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_LOAD | stepping RB1_A 0..NWORDS-1 and capturing bytes into the buffer
// S_SEND | sen low, shifting the 21-bit {frame, plane word} out on sd
// S_GAP  | sen high idle between frames, GAP cycles
// S_DONE | all frames sent, S1_done held until reset
module s1_serializer
  import s1_serializer_pkg::*;
#(
  parameter int NWORDS = DATA_BITS,
  parameter int GAP    = 2
) (
  input logic             clk,
  input logic             rst,
  s1_serializer_if.master rb
);

  localparam int GW   = $clog2(GAP + 1);
  localparam int WLEN = ADDR_BITS + NWORDS;

  localparam logic [4:0]           LAST_ADDR  = 5'(NWORDS - 1);
  localparam logic [4:0]           LOAD_END   = 5'(NWORDS);
  localparam logic [4:0]           LAST_BIT   = 5'(WLEN - 1);
  localparam logic [ADDR_BITS-1:0] LAST_FRAME = ADDR_BITS'(NFRAMES - 1);
  localparam logic [GW-1:0]        GAP_LOAD   = GW'(GAP - 1);

  state_e               state_q, state_d;
  logic [4:0]           lcnt_q, lcnt_d;
  logic [4:0]           rb1_a_q, rb1_a_d;
  logic [4:0]           bitcnt_q, bitcnt_d;
  logic [ADDR_BITS-1:0] frame_q, frame_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic                 done_q, done_d;
  logic                 sen_q, sen_d;
  logic                 sd_q, sd_d;
  logic [7:0]           rb_buf_q [NWORDS];
  logic [7:0]           rb_buf_d [NWORDS];

  logic [NWORDS-1:0]    plane_word;
  logic [WLEN-1:0]      shift_word;

  // plane word for the frame being (or about to be) sent
  s1_bitplane_mux #(
    .N (NWORDS)
  ) u_mux (
    .bytes_i (rb_buf_q),
    .plane_i (frame_d),
    .word_o  (plane_word)
  );

  // state, counters and buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      lcnt_q   <= '0;
      rb1_a_q  <= '0;
      bitcnt_q <= '0;
      frame_q  <= '0;
      gcnt_q   <= '0;
      done_q   <= 1'b0;
      sen_q    <= 1'b1;
      sd_q     <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        rb_buf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      rb1_a_q  <= rb1_a_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      gcnt_q   <= gcnt_d;
      done_q   <= done_d;
      sen_q    <= sen_d;
      sd_q     <= sd_d;
      for (int i = 0; i < NWORDS; i++) begin
        rb_buf_q[i] <= rb_buf_d[i];
      end
    end
  end

  // next-state and counter logic
  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    rb1_a_d  = rb1_a_q;
    bitcnt_d = bitcnt_q;
    frame_d  = frame_q;
    gcnt_d   = gcnt_q;
    done_d   = done_q;
    for (int i = 0; i < NWORDS; i++) begin
      rb_buf_d[i] = rb_buf_q[i];
    end

    unique case (state_q)
      S_LOAD: begin
        // RB1_Q reflects the address presented one cycle earlier
        if (lcnt_q != 5'd0) begin
          rb_buf_d[lcnt_q - 5'd1] = rb.RB1_Q;
        end
        if (lcnt_q == LOAD_END) begin
          state_d  = S_SEND;
          bitcnt_d = '0;
          frame_d  = '0;
        end else begin
          lcnt_d  = lcnt_q + 5'd1;
          rb1_a_d = (rb1_a_q == LAST_ADDR) ? LAST_ADDR : rb1_a_q + 5'd1;
        end
      end
      S_SEND: begin
        if (bitcnt_q == LAST_BIT) begin
          if (frame_q == LAST_FRAME) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gcnt_d  = GAP_LOAD;
          end
        end else begin
          bitcnt_d = bitcnt_q + 5'd1;
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d  = S_SEND;
          frame_d  = frame_q + 1'b1;
          bitcnt_d = '0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // registered serial outputs, derived from the upcoming state/counters
  always_comb begin
    sen_d      = 1'b1;
    sd_d       = 1'b0;
    shift_word = {frame_d, plane_word};
    if (state_d == S_SEND) begin
      sen_d = 1'b0;
      sd_d  = shift_word[LAST_BIT - bitcnt_d];
    end
  end

  assign rb.RB1_RW  = 1'b1;
  assign rb.RB1_D   = '0;
  assign rb.RB1_A   = rb1_a_q;
  assign rb.sen     = sen_q;
  assign rb.sd      = sd_q;
  assign rb.S1_done = done_q;

endmodule

// File: tb/tb_s1_serializer.sv
// Directed bench for s1_serializer: RB1 memory model, S2-style frame
// receiver, table of expected frame words and a mid-frame reset sequence.
module tb_s1_serializer;

  logic clk;
  logic rst;
  s1_serializer_if bus ();

  s1_serializer #(.NWORDS(18), .GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .rb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RB1: synchronous read, data valid the cycle after the address
  logic [7:0] mem [32];
  initial bus.RB1_Q = 8'h00;
  always @(posedge clk) bus.RB1_Q <= mem[bus.RB1_A];

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // receiver model and timing monitor
  logic [17:0] rb2 [8];
  int          order [8];
  int          nrx, lo_run, hi_run, ngaps;
  int          run_err, gap_err, a_err, ctl_err, sd_err;
  int          first_low, done_cyc;
  logic [20:0] shreg;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rb2[i]   = 18'h12345;
        order[i] = -1;
      end
      nrx = 0; lo_run = 0; hi_run = 0; ngaps = 0;
      run_err = 0; gap_err = 0; a_err = 0; ctl_err = 0; sd_err = 0;
      first_low = -1; done_cyc = -1; shreg = '0;
    end else begin
      if (int'(bus.RB1_A) != ((cyc > 17) ? 17 : cyc)) a_err++;
      if (bus.RB1_RW !== 1'b1 || bus.RB1_D !== 8'h00) ctl_err++;
      if (bus.sen === 1'b0) begin
        if (first_low < 0) first_low = cyc + 1;
        if (hi_run > 0 && nrx > 0) begin
          ngaps++;
          if (hi_run != 2) gap_err++;
        end
        hi_run = 0;
        lo_run++;
        shreg = {shreg[19:0], bus.sd};
      end else begin
        if (lo_run > 0) begin
          if (lo_run != 21) run_err++;
          else begin
            rb2[shreg[20:18]] = shreg[17:0];
            if (nrx < 8) order[nrx] = int'(shreg[20:18]);
            nrx++;
          end
        end
        lo_run = 0;
        hi_run++;
        if (bus.sd !== 1'b0) sd_err++;
      end
      if (bus.S1_done === 1'b1 && done_cyc < 0) done_cyc = cyc + 1;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_mem(input int pat);
    for (int j = 0; j < 32; j++) begin
      if (j >= 18)       mem[j] = 8'hEE;
      else if (pat == 0) mem[j] = 8'(j);
      else if (pat == 1) mem[j] = 8'hFF;
      else               mem[j] = (j == 5) ? 8'h80 : 8'h00;
    end
  endtask

  task automatic reset_and_release(input int pat);
    rst = 1'b0;
    set_mem(pat);
    repeat (3) @(negedge clk);
    chk("rst_sen",  32'(bus.sen), 32'd1);
    chk("rst_sd",   32'(bus.sd), 32'd0);
    chk("rst_done", 32'(bus.S1_done), 32'd0);
    chk("rst_addr", 32'(bus.RB1_A), 32'd0);
    chk("rst_rw_d", {23'd0, bus.RB1_RW, bus.RB1_D}, {23'd0, 1'b1, 8'h00});
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_and_check_run();
    int bad;
    for (int i = 0; i < 400 && bus.S1_done !== 1'b1; i++) @(negedge clk);
    chk("done_seen", 32'(bus.S1_done), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("done_cycle",  32'(done_cyc), 32'd202);
    chk("first_low",   32'(first_low), 32'd20);
    chk("frames_rx",   32'(nrx), 32'd8);
    chk("run_len_err", 32'(run_err), 32'd0);
    chk("gap_len_err", 32'(gap_err), 32'd0);
    chk("gap_count",   32'(ngaps), 32'd7);
    chk("rb1_a_seq",   32'(a_err), 32'd0);
    chk("rb1_rw_d",    32'(ctl_err), 32'd0);
    chk("sd_idle",     32'(sd_err), 32'd0);
    chk("done_sticky", {30'd0, bus.S1_done, bus.sen}, 32'd3);
    bad = 0;
    for (int i = 0; i < 8; i++) if (order[i] != i) bad++;
    chk("addr_order", 32'(bad), 32'd0);
    chk("last_addr",  32'(order[7]), 32'd7);
  endtask

  typedef struct {
    int          pat;
    int          frame;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs [24];

  initial begin
    int cur;
    rst = 1'b0;
    set_mem(0);

    // pattern 0: byte j = j; pattern 1: all 8'hFF;
    // pattern 2: byte 5 = 8'h80 -> frame 7 data bit 5 only
    // (D5 is the 13th data bit on the wire, since D17 goes first)
    vecs[0]  = '{0, 0, 18'h2AAAA};
    vecs[1]  = '{0, 1, 18'h0CCCC};
    vecs[2]  = '{0, 2, 18'h0F0F0};
    vecs[3]  = '{0, 3, 18'h0FF00};
    vecs[4]  = '{0, 4, 18'h30000};
    vecs[5]  = '{0, 5, 18'h00000};
    vecs[6]  = '{0, 6, 18'h00000};
    vecs[7]  = '{0, 7, 18'h00000};
    for (int i = 0; i < 8; i++) vecs[8 + i] = '{1, i, 18'h3FFFF};
    for (int i = 0; i < 7; i++) vecs[16 + i] = '{2, i, 18'h00000};
    vecs[23] = '{2, 7, 18'h00020};

    cur = -1;
    for (int v = 0; v < 24; v++) begin
      if (vecs[v].pat != cur) begin
        cur = vecs[v].pat;
        reset_and_release(cur);
        wait_and_check_run();
      end
      chk($sformatf("pat%0d_frame%0d", vecs[v].pat, vecs[v].frame),
          32'(rb2[vecs[v].frame]), 32'(vecs[v].exp));
    end

    // reset during frame 3, bitcnt 10 (cycle 99), then full restart
    reset_and_release(0);
    for (int i = 0; i < 300 && cyc != 98; i++) @(negedge clk);
    #1;
    chk("mid_cycle_reached", 32'(cyc), 32'd98);
    chk("mid_frames_before", 32'(nrx), 32'd3);
    chk("mid_bits_in_frame", 32'(lo_run), 32'd11);
    chk("mid_sen_low",       32'(bus.sen), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_sen",  32'(bus.sen), 32'd1);
    chk("abort_done", 32'(bus.S1_done), 32'd0);
    chk("abort_sd",   32'(bus.sd), 32'd0);
    reset_and_release(0);
    wait_and_check_run();
    chk("restart_frame0", 32'(rb2[0]), 32'h2AAAA);
    chk("restart_frame4", 32'(rb2[4]), 32'h30000);
    chk("restart_first",  32'(order[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
